ingress_writer: RTL and testbench

INGRESS_WRITER -- requirements
Module: ingress_writer

---
 rtl/ingress_writer.sv | 172 +++++++++++++++++
 tb/tb_ingress_writer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_writer.sv
// Three-port ingress writer: accepts words per port, writes them into per-port input RAMs
// and tells the downstream scheduler when the initial fill phase is over.
module ingress_writer #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned QUIET_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_data1,
  input  logic [31:0]       in_data2,
  input  logic [31:0]       in_data3,
  input  logic              in_valid1,
  input  logic              in_valid2,
  input  logic              in_valid3,
  output logic              in_ready1,
  output logic              in_ready2,
  output logic              in_ready3,
  output logic              ram_wren1,
  output logic              ram_wren2,
  output logic              ram_wren3,
  output logic [31:0]       ram_wr_data1,
  output logic [31:0]       ram_wr_data2,
  output logic [31:0]       ram_wr_data3,
  output logic [ADDR_W-1:0] ram_wr_addr1,
  output logic [ADDR_W-1:0] ram_wr_addr2,
  output logic [ADDR_W-1:0] ram_wr_addr3,
  output logic [ADDR_W-1:0] input_ram_wr_add1,
  output logic [ADDR_W-1:0] input_ram_wr_add2,
  output logic [ADDR_W-1:0] input_ram_wr_add3,
  output logic              write_enable,
  output logic [1:0]        state_o
);

  localparam int unsigned NP = 3;
  localparam int unsigned QW = $clog2(QUIET_CYC + 1);
  localparam logic [ADDR_W-1:0] WP_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] WP_LAST = WP_MAX - ADDR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FILL = 2'b01,
    S_RUN  = 2'b10
  } state_t;

  logic [31:0]       w_data  [NP];
  logic [NP-1:0]     w_valid;
  logic [NP-1:0]     w_ready;
  logic [NP-1:0]     w_acc;
  logic              w_any_acc;
  logic              w_full_any;

  logic [ADDR_W-1:0] r_wp      [NP];
  logic [ADDR_W-1:0] r_cnt     [NP];
  logic              r_wren    [NP];
  logic [31:0]       r_wr_data [NP];
  logic [ADDR_W-1:0] r_wr_addr [NP];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [QW-1:0]     r_quiet;
  logic [QW-1:0]     w_quiet_nxt;
  logic              r_we;

  assign w_data[0] = in_data1;
  assign w_data[1] = in_data2;
  assign w_data[2] = in_data3;
  assign w_valid   = {in_valid3, in_valid2, in_valid1};

  // Ready while the pointer is below the last address; the top address is never written.
  always_comb begin
    w_ready    = '0;
    w_full_any = 1'b0;
    for (int p = 0; p < int'(NP); p++) begin
      w_ready[p] = (r_wp[p] != WP_MAX) && !reset;
    end
    w_acc = w_valid & w_ready;
    for (int p = 0; p < int'(NP); p++) begin
      if ((r_wp[p] == WP_MAX) || (w_acc[p] && (r_wp[p] == WP_LAST))) begin
        w_full_any = 1'b1;
      end
    end
  end

  assign w_any_acc = |w_acc;

  assign in_ready1 = w_ready[0];
  assign in_ready2 = w_ready[1];
  assign in_ready3 = w_ready[2];

  // Per-port pointer, RAM write stage and committed count (count trails the pointer by one cycle).
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < int'(NP); p++) begin
        r_wp[p]      <= '0;
        r_cnt[p]     <= '0;
        r_wren[p]    <= 1'b0;
        r_wr_data[p] <= '0;
        r_wr_addr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < int'(NP); p++) begin
        r_cnt[p]  <= r_wp[p];
        r_wren[p] <= w_acc[p];
        if (w_acc[p]) begin
          r_wr_data[p] <= w_data[p];
          r_wr_addr[p] <= r_wp[p];
          r_wp[p]      <= r_wp[p] + ADDR_W'(1);
        end
      end
    end
  end

  // Phase state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_quiet <= '0;
      r_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_quiet <= w_quiet_nxt;
      r_we    <= (w_state_nxt == S_RUN);
    end
  end

  // Next phase: fill ends after QUIET_CYC idle cycles or when any port fills up.
  always_comb begin
    w_state_nxt = r_state;
    w_quiet_nxt = r_quiet;
    case (r_state)
      S_IDLE: begin
        w_quiet_nxt = '0;
        if (w_any_acc) begin
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (w_any_acc) begin
          w_quiet_nxt = '0;
        end else if (r_quiet != QW'(QUIET_CYC)) begin
          w_quiet_nxt = r_quiet + QW'(1);
        end
        if (w_full_any || (w_quiet_nxt == QW'(QUIET_CYC))) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_state_nxt = S_RUN;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_quiet_nxt = '0;
      end
    endcase
  end

  assign ram_wren1         = r_wren[0];
  assign ram_wren2         = r_wren[1];
  assign ram_wren3         = r_wren[2];
  assign ram_wr_data1      = r_wr_data[0];
  assign ram_wr_data2      = r_wr_data[1];
  assign ram_wr_data3      = r_wr_data[2];
  assign ram_wr_addr1      = r_wr_addr[0];
  assign ram_wr_addr2      = r_wr_addr[1];
  assign ram_wr_addr3      = r_wr_addr[2];
  assign input_ram_wr_add1 = r_cnt[0];
  assign input_ram_wr_add2 = r_cnt[1];
  assign input_ram_wr_add3 = r_cnt[2];
  assign write_enable      = r_we;
  assign state_o           = r_state;

endmodule

// File: tb/tb_ingress_writer.sv
// Bench for ingress_writer: per-cycle comparison against a word-counting model,
// plus directed scenarios with literal expectations at fixed cycles.
module tb_ingress_writer;

  localparam int unsigned ADDR_W = 12;
  localparam int          QUIET  = 16;
  localparam int          CAP    = 4095;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       in_data  [3];
  logic              in_valid [3];
  logic              ready    [3];
  logic              wren     [3];
  logic [31:0]       wdata    [3];
  logic [ADDR_W-1:0] waddr    [3];
  logic [ADDR_W-1:0] wcnt     [3];
  logic              write_enable;
  logic [1:0]        state_o;

  always #5 clk = ~clk;

  ingress_writer #(.ADDR_W(ADDR_W), .QUIET_CYC(QUIET)) dut (
    .clk(clk), .reset(reset),
    .in_data1(in_data[0]), .in_data2(in_data[1]), .in_data3(in_data[2]),
    .in_valid1(in_valid[0]), .in_valid2(in_valid[1]), .in_valid3(in_valid[2]),
    .in_ready1(ready[0]), .in_ready2(ready[1]), .in_ready3(ready[2]),
    .ram_wren1(wren[0]), .ram_wren2(wren[1]), .ram_wren3(wren[2]),
    .ram_wr_data1(wdata[0]), .ram_wr_data2(wdata[1]), .ram_wr_data3(wdata[2]),
    .ram_wr_addr1(waddr[0]), .ram_wr_addr2(waddr[1]), .ram_wr_addr3(waddr[2]),
    .input_ram_wr_add1(wcnt[0]), .input_ram_wr_add2(wcnt[1]), .input_ram_wr_add3(wcnt[2]),
    .write_enable(write_enable), .state_o(state_o)
  );

  typedef struct {
    int          at;
    int          sig;
    int          port;
    logic [31:0] exp;
  } lit_t;

  lit_t  lits[$];
  int    cyc = 0;
  bit    done = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  string sig_name [7] = '{"wren", "addr", "data", "count", "ready", "write_enable", "state"};

  // Model: accepted-word counts plus the expected registered outputs for the current cycle.
  int          m_cnt    [3];
  int          m_commit [3];
  logic        m_wren   [3];
  logic [31:0] m_addr   [3];
  logic [31:0] m_data   [3];
  int          m_phase = 0;
  int          m_quiet = 0;

  function automatic logic [31:0] dut_sig(int sig, int p);
    case (sig)
      0:       return 32'(wren[p]);
      1:       return 32'(waddr[p]);
      2:       return wdata[p];
      3:       return 32'(wcnt[p]);
      4:       return 32'(ready[p]);
      5:       return 32'(write_enable);
      default: return 32'(state_o);
    endcase
  endfunction

  task automatic check(string name, int p, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s port%0d cycle %0d: got %0h expected %0h", name, p + 1, cyc, act, exp);
    end
  endtask

  task automatic expect_at(int at, int sig, int p, logic [31:0] v);
    lit_t l;
    l.at = at; l.sig = sig; l.port = p; l.exp = v;
    lits.push_back(l);
  endtask

  // Single compare/model process.
  initial begin
    bit acc_any;
    bit full_any;
    for (int p = 0; p < 3; p++) begin
      m_cnt[p] = 0; m_commit[p] = 0; m_wren[p] = 1'b0; m_addr[p] = '0; m_data[p] = '0;
    end
    while (!done) begin
      @(negedge clk);
      for (int p = 0; p < 3; p++) begin
        check("wren", p, 32'(wren[p]), 32'(m_wren[p]));
        check("addr", p, 32'(waddr[p]), m_addr[p]);
        check("data", p, wdata[p], m_data[p]);
        check("count", p, 32'(wcnt[p]), 32'(m_commit[p]));
        check("ready", p, 32'(ready[p]), 32'(!reset && (m_cnt[p] < CAP)));
      end
      check("write_enable", 0, 32'(write_enable), 32'(m_phase == 2));
      check("state", 0, 32'(state_o), 32'(m_phase));
      for (int i = lits.size() - 1; i >= 0; i--) begin
        if (lits[i].at == cyc) begin
          check({"lit_", sig_name[lits[i].sig]}, lits[i].port,
                dut_sig(lits[i].sig, lits[i].port), lits[i].exp);
          lits.delete(i);
        end
      end
      // Advance the model by the effect of this cycle's inputs at the coming edge.
      if (reset) begin
        for (int p = 0; p < 3; p++) begin
          m_cnt[p] = 0; m_commit[p] = 0; m_wren[p] = 1'b0; m_addr[p] = '0; m_data[p] = '0;
        end
        m_phase = 0;
        m_quiet = 0;
      end else begin
        acc_any  = 1'b0;
        full_any = 1'b0;
        for (int p = 0; p < 3; p++) begin
          m_commit[p] = m_cnt[p];
          if (in_valid[p] && (m_cnt[p] < CAP)) begin
            m_wren[p] = 1'b1;
            m_addr[p] = 32'(m_cnt[p]);
            m_data[p] = in_data[p];
            m_cnt[p]++;
            acc_any = 1'b1;
          end else begin
            m_wren[p] = 1'b0;
          end
          if (m_cnt[p] == CAP) full_any = 1'b1;
        end
        if (m_phase == 0) begin
          if (acc_any) m_phase = 1;
        end else if (m_phase == 1) begin
          if (acc_any) m_quiet = 0;
          else if (m_quiet < QUIET) m_quiet++;
          if (full_any || (m_quiet == QUIET)) m_phase = 2;
        end
      end
      cyc++;
      if (cyc > 90000) begin
        $display("FAIL timeout: cycle %0d reached, limit 90000", cyc);
        $fatal(1);
      end
    end
    foreach (lits[i]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unreached_%s port%0d: cycle %0d never checked, expected %0h",
               sig_name[lits[i].sig], lits[i].port + 1, lits[i].at, lits[i].exp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int p = 0; p < 3; p++) in_valid[p] = 1'b0;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    idle_inputs();
    repeat (n) tick();
    reset = 1'b0;
  endtask

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int c;
    int l;
    int r;
    reset = 1'b1;
    for (int p = 0; p < 3; p++) begin
      in_valid[p] = 1'b0;
      in_data[p]  = '0;
    end
    repeat (2) tick();
    reset = 1'b0;
    expect_at(cyc, 6, 0, 32'd0);
    expect_at(cyc, 3, 0, 32'd0);
    tick();

    // Single word on port 1.
    do_reset(2);
    c = cyc;
    in_valid[0] = 1'b1; in_data[0] = 32'h0000_0005;
    expect_at(c + 1, 0, 0, 32'd1);
    expect_at(c + 1, 1, 0, 32'd0);
    expect_at(c + 1, 2, 0, 32'h5);
    expect_at(c + 1, 6, 0, 32'd1);
    expect_at(c + 2, 3, 0, 32'd1);
    expect_at(c + 2, 0, 0, 32'd0);
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();

    // Burst of 10 on port 2, then quiet.
    do_reset(2);
    c = cyc;
    for (int i = 0; i < 10; i++) begin
      in_valid[1] = 1'b1; in_data[1] = 32'h100 + 32'(i);
      tick();
    end
    in_valid[1] = 1'b0;
    l = c + 9;
    expect_at(l + 16, 5, 0, 32'd0);
    expect_at(l + 17, 5, 0, 32'd1);
    expect_at(l + 17, 6, 0, 32'd2);
    expect_at(l + 17, 3, 1, 32'd10);
    expect_at(l + 17, 3, 0, 32'd0);
    expect_at(l + 17, 3, 2, 32'd0);
    repeat (20) tick();

    // All three ports every cycle for 8 cycles.
    do_reset(2);
    c = cyc;
    for (int p = 0; p < 3; p++) begin
      expect_at(c + 1, 0, p, 32'd1);
      expect_at(c + 1, 1, p, 32'd0);
      expect_at(c + 8, 1, p, 32'd7);
      expect_at(c + 9, 3, p, 32'd8);
      expect_at(c + 9, 0, p, 32'd0);
    end
    expect_at(c + 8, 2, 1, 32'h0000_0207);
    for (int i = 0; i < 8; i++) begin
      for (int p = 0; p < 3; p++) begin
        in_valid[p] = 1'b1; in_data[p] = (32'(p + 1) << 8) | 32'(i);
      end
      tick();
    end
    idle_inputs();
    repeat (3) tick();

    // One word every 15 cycles: the fill phase must not end.
    do_reset(2);
    l = 0;
    for (int k = 0; k < 5; k++) begin
      c = cyc;
      l = c;
      in_valid[0] = 1'b1; in_data[0] = 32'hA0 + 32'(k);
      expect_at(c + 14, 5, 0, 32'd0);
      tick();
      in_valid[0] = 1'b0;
      if (k < 4) repeat (14) tick();
    end
    expect_at(l + 16, 5, 0, 32'd0);
    expect_at(l + 17, 5, 0, 32'd1);
    repeat (20) tick();

    // Reset in RUN with a word presented: it must not be written.
    c = cyc;
    expect_at(c, 6, 0, 32'd2);
    in_valid[0] = 1'b1; in_data[0] = 32'hDEAD_BEEF;
    reset = 1'b1;
    expect_at(c, 4, 0, 32'd0);
    expect_at(c + 1, 0, 0, 32'd0);
    expect_at(c + 1, 1, 0, 32'd0);
    expect_at(c + 1, 2, 0, 32'd0);
    expect_at(c + 1, 5, 0, 32'd0);
    expect_at(c + 1, 6, 0, 32'd0);
    tick();
    reset = 1'b0;
    in_data[0] = 32'h77;
    expect_at(c + 2, 0, 0, 32'd1);
    expect_at(c + 2, 1, 0, 32'd0);
    expect_at(c + 2, 2, 0, 32'h77);
    tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();

    // Port 3 driven until full; held word only accepted after reset.
    do_reset(2);
    c = cyc;
    expect_at(c + 4094, 4, 2, 32'd1);
    expect_at(c + 4095, 4, 2, 32'd0);
    expect_at(c + 4095, 0, 2, 32'd1);
    expect_at(c + 4095, 1, 2, 32'd4094);
    expect_at(c + 4095, 6, 0, 32'd2);
    expect_at(c + 4095, 5, 0, 32'd1);
    expect_at(c + 4096, 0, 2, 32'd0);
    expect_at(c + 4096, 3, 2, 32'd4095);
    in_valid[2] = 1'b1;
    for (int i = 0; i < 4100; i++) begin
      in_data[2] = (i < CAP) ? 32'(i) : 32'(CAP);
      tick();
    end
    r = cyc;
    reset = 1'b1;
    expect_at(r, 4, 2, 32'd0);
    tick();
    reset = 1'b0;
    expect_at(r + 1, 4, 2, 32'd1);
    expect_at(r + 2, 0, 2, 32'd1);
    expect_at(r + 2, 1, 2, 32'd0);
    expect_at(r + 2, 2, 2, 32'(CAP));
    tick();
    in_valid[2] = 1'b0;
    repeat (3) tick();

    // Randomized traffic with occasional gaps and resets.
    do_reset(2);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      if ($urandom_range(0, 79) == 0) begin
        idle_inputs();
        repeat ($urandom_range(14, 22)) tick();
      end
      for (int p = 0; p < 3; p++) begin
        in_valid[p] = ($urandom_range(0, 99) < 40);
        in_data[p]  = $urandom;
      end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
    repeat (5) tick();
    done = 1'b1;
  end

endmodule
